// File: rtl/ps2_kbmat_pkg.sv
// rtl/ps2_kbmat_pkg.sv - shared types, prefix codes and key map for the PS/2 matrix front end
package ps2_pkg;

  typedef enum logic [1:0] {F_IDLE, F_DATA, F_PAR, F_STOP} frame_state_t;
  typedef enum logic [2:0] {D_NORM, D_BRK, D_EXT, D_EXTBRK, D_SKIP} dec_state_t;

  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_E1 = 8'hE1;
  localparam logic [7:0] PFX_F0 = 8'hF0;
  localparam logic [7:0] PFX_AA = 8'hAA;
  localparam logic [7:0] PFX_FA = 8'hFA;
  localparam logic [7:0] PFX_FE = 8'hFE;
  localparam logic [7:0] PFX_00 = 8'h00;
  localparam logic [7:0] PFX_FF = 8'hFF;

  localparam logic [2:0] SKIP_LEN = 3'd7;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
    logic [5:0] idx;
  } key_ent_t;

  localparam int KEY_N = 12;

  // Matrix index is row*8+col of the Z88 keyboard
  localparam key_ent_t [KEY_N-1:0] KEY_MAP = {
    {1'b0, 8'h5A, 6'd6},
    {1'b0, 8'h76, 6'd61},
    {1'b0, 8'h12, 6'd54},
    {1'b0, 8'h59, 6'd63},
    {1'b0, 8'h1C, 6'd45},
    {1'b0, 8'h29, 6'd46},
    {1'b0, 8'h66, 6'd7},
    {1'b0, 8'h0D, 6'd60},
    {1'b1, 8'h75, 6'd11},
    {1'b1, 8'h72, 6'd10},
    {1'b1, 8'h6B, 6'd12},
    {1'b1, 8'h74, 6'd13}
  };

endpackage

// File: rtl/ps2_kbmat_if.sv
// rtl/ps2_kbmat_if.sv - PS/2 pins and key matrix outputs
interface ps2_kbmat_if;
  logic        ps2_clk;
  logic        ps2_dat;
  logic [63:0] kbmat;
  logic        kbact;
  logic        kb_err;

  modport master (output ps2_clk, ps2_dat, input kbmat, kbact, kb_err);
  modport slave  (input ps2_clk, ps2_dat, output kbmat, kbact, kb_err);
endinterface

// File: rtl/ps2_kbmat_keymap.sv
// rtl/ps2_kbmat_keymap.sv - combinational scan code to matrix index lookup
module ps2_keymap
  import ps2_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output logic       hit,
  output logic [5:0] idx
);

  always_comb begin
    hit = 1'b0;
    idx = 6'd0;
    for (int i = 0; i < KEY_N; i++) begin
      if (KEY_MAP[i].ext == ext && KEY_MAP[i].code == code) begin
        hit = 1'b1;
        idx = KEY_MAP[i].idx;
      end
    end
  end

endmodule

// File: rtl/ps2_kbmat.sv
// rtl/ps2_kbmat.sv - PS/2 receiver and set-2 decoder driving the 64-bit key matrix
module ps2_kbmat
  import ps2_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd9830,
  parameter int          FILT    = 3
) (
  input  logic          mck,
  input  logic          rin_n,
  ps2_kbmat_if.slave    bus
);

  localparam int FW = (FILT > 1) ? $clog2(FILT + 1) : 1;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt;
  logic [FW-1:0] fcnt;
  logic          fall;

  frame_state_t  fst;
  logic [2:0]    bcnt;
  logic [7:0]    sh;
  logic          par;
  logic [15:0]   tcnt;
  logic          byte_vld;
  logic [7:0]    byte_q;
  logic          err;

  dec_state_t    dst;
  logic [2:0]    skip;
  logic [63:0]   mat;
  logic          act;

  logic          ext;
  logic          hit;
  logic [5:0]    idx;

  // Synchronizer and clock glitch filter; lines idle high
  always_ff @(posedge mck) begin
    if (!rin_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      filt   <= 1'b1;
      fcnt   <= '0;
      fall   <= 1'b0;
    end else begin
      clk_s1 <= bus.ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= bus.ps2_dat;
      dat_s2 <= dat_s1;
      fall   <= (clk_s2 != filt) && (fcnt == FW'(FILT - 1)) && !clk_s2;
      if (clk_s2 == filt) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILT - 1)) begin
        filt <= clk_s2;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge mck) begin
    if (!rin_n) begin
      fst      <= F_IDLE;
      bcnt     <= 3'd0;
      sh       <= 8'd0;
      par      <= 1'b0;
      tcnt     <= 16'd0;
      byte_vld <= 1'b0;
      byte_q   <= 8'd0;
      err      <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      err      <= 1'b0;
      if (fall) tcnt <= 16'd0;
      else if (tcnt != TIMEOUT) tcnt <= tcnt + 16'd1;

      if (fall) begin
        case (fst)
          F_IDLE: begin
            if (!dat_s2) begin
              fst  <= F_DATA;
              bcnt <= 3'd0;
            end
          end
          F_DATA: begin
            sh <= {dat_s2, sh[7:1]};
            if (bcnt == 3'd7) fst <= F_PAR;
            else bcnt <= bcnt + 3'd1;
          end
          F_PAR: begin
            par <= dat_s2;
            fst <= F_STOP;
          end
          default: begin
            if (dat_s2 && (^{par, sh})) begin
              byte_vld <= 1'b1;
              byte_q   <= sh;
            end else begin
              err <= 1'b1;
            end
            fst  <= F_IDLE;
            bcnt <= 3'd0;
          end
        endcase
      end else if (fst != F_IDLE && tcnt == TIMEOUT) begin
        fst  <= F_IDLE;
        bcnt <= 3'd0;
        err  <= 1'b1;
      end
    end
  end

  assign ext = (dst == D_EXT) || (dst == D_EXTBRK);

  ps2_keymap u_keymap (
    .ext  (ext),
    .code (byte_q),
    .hit  (hit),
    .idx  (idx)
  );

  always_ff @(posedge mck) begin
    if (!rin_n) begin
      dst  <= D_NORM;
      skip <= 3'd0;
      mat  <= 64'd0;
      act  <= 1'b0;
    end else begin
      act <= |mat;
      if (byte_vld) begin
        case (dst)
          D_NORM: begin
            case (byte_q)
              PFX_E0: dst <= D_EXT;
              PFX_F0: dst <= D_BRK;
              PFX_E1: begin
                dst  <= D_SKIP;
                skip <= SKIP_LEN;
              end
              PFX_00, PFX_FF: mat <= 64'd0;
              PFX_AA, PFX_FA, PFX_FE: ;
              default: if (hit) mat[idx] <= 1'b1;
            endcase
          end
          D_BRK: begin
            if (hit) mat[idx] <= 1'b0;
            dst <= D_NORM;
          end
          D_EXT: begin
            if (byte_q == PFX_F0) begin
              dst <= D_EXTBRK;
            end else begin
              if (hit) mat[idx] <= 1'b1;
              dst <= D_NORM;
            end
          end
          D_EXTBRK: begin
            if (hit) mat[idx] <= 1'b0;
            dst <= D_NORM;
          end
          default: begin
            skip <= skip - 3'd1;
            if (skip == 3'd1) dst <= D_NORM;
          end
        endcase
      end
    end
  end

  assign bus.kbmat  = mat;
  assign bus.kbact  = act;
  assign bus.kb_err = err;

endmodule

// File: tb/tb_ps2_kbmat.sv
// tb/tb_ps2_kbmat.sv - randomized and directed bench for ps2_kbmat against a scan-code model
module tb_ps2_kbmat;

  localparam logic [15:0] TO = 16'd600;

  logic mck = 1'b0;
  logic rin_n = 1'b0;
  ps2_kbmat_if bus();

  ps2_kbmat #(.TIMEOUT(TO), .FILT(3)) dut (
    .mck   (mck),
    .rin_n (rin_n),
    .bus   (bus)
  );

  always #5 mck = ~mck;

  int n_chk = 0;
  int n_pass = 0;
  int err_pulses = 0;
  int err_cycles = 0;
  logic err_d = 1'b0;

  logic [63:0] m_mat = 64'd0;
  bit m_ext = 0;
  bit m_brk = 0;
  int m_skip = 0;

  always @(negedge mck) begin
    if (bus.kb_err === 1'b1) err_cycles++;
    if (bus.kb_err === 1'b1 && err_d !== 1'b1) err_pulses++;
    err_d = bus.kb_err;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  function automatic int lookup(input bit e, input logic [7:0] c);
    case ({e, c})
      {1'b0, 8'h5A}: return 6;
      {1'b0, 8'h76}: return 61;
      {1'b0, 8'h12}: return 54;
      {1'b0, 8'h59}: return 63;
      {1'b0, 8'h1C}: return 45;
      {1'b0, 8'h29}: return 46;
      {1'b0, 8'h66}: return 7;
      {1'b0, 8'h0D}: return 60;
      {1'b1, 8'h75}: return 11;
      {1'b1, 8'h72}: return 10;
      {1'b1, 8'h6B}: return 12;
      {1'b1, 8'h74}: return 13;
      default:       return -1;
    endcase
  endfunction

  task automatic model_clear();
    m_mat = 64'd0; m_ext = 0; m_brk = 0; m_skip = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int k;
    if (m_skip > 0) begin
      m_skip--;
    end else if (!m_ext && !m_brk) begin
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE1) m_skip = 7;
      else if (b == 8'h00 || b == 8'hFF) m_mat = 64'd0;
      else if (b != 8'hAA && b != 8'hFA && b != 8'hFE) begin
        k = lookup(1'b0, b);
        if (k >= 0) m_mat[k] = 1'b1;
      end
    end else if (m_ext && !m_brk && b == 8'hF0) begin
      m_brk = 1;
    end else begin
      k = lookup(m_ext, b);
      if (k >= 0) m_mat[k] = !m_brk;
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic send_bit(input logic v);
    bus.ps2_dat = v;
    repeat (6) @(posedge mck);
    bus.ps2_clk = 1'b0;
    repeat (10) @(posedge mck);
    bus.ps2_clk = 1'b1;
    repeat (6) @(posedge mck);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(!bad_stop);
    bus.ps2_dat = 1'b1;
    repeat (4) @(posedge mck);
  endtask

  task automatic key(input logic [7:0] b, input string tag);
    send_frame(b, 0, 0);
    model_byte(b);
    @(negedge mck);
    check({tag, "_mat"}, bus.kbmat, m_mat);
    check({tag, "_act"}, {63'd0, bus.kbact}, {63'd0, |m_mat});
  endtask

  task automatic bad_frame(input logic [7:0] b, input bit bp, input bit bs, input string tag);
    int p0, c0;
    p0 = err_pulses; c0 = err_cycles;
    send_frame(b, bp, bs);
    @(negedge mck);
    check({tag, "_pulses"}, 64'(err_pulses - p0), 64'd1);
    check({tag, "_cycles"}, 64'(err_cycles - c0), 64'd1);
    check({tag, "_mat"}, bus.kbmat, m_mat);
  endtask

  initial begin
    logic [7:0] pool [18];
    logic [7:0] b;
    int p0, c0;
    pool = '{8'h5A, 8'h76, 8'h12, 8'h59, 8'h1C, 8'h29, 8'h66, 8'h0D, 8'h75,
             8'h72, 8'h6B, 8'h74, 8'hF0, 8'hE0, 8'hE1, 8'h00, 8'h33, 8'hAA};
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    rin_n = 1'b0;
    repeat (4) @(posedge mck);
    #1;
    check("rst_mat", bus.kbmat, 64'd0);
    check("rst_act", {63'd0, bus.kbact}, 64'd0);
    check("rst_err", {63'd0, bus.kb_err}, 64'd0);
    rin_n = 1'b1;
    repeat (4) @(posedge mck);

    key(8'h1C, "a_make");
    check("a_bit45", {63'd0, bus.kbmat[45]}, 64'd1);
    key(8'hF0, "a_f0");
    key(8'h1C, "a_break");
    key(8'hE0, "up_e0");
    key(8'h75, "up_make");
    check("up_bit11", {63'd0, bus.kbmat[11]}, 64'd1);
    key(8'hE0, "up_e0b");
    key(8'hF0, "up_f0");
    key(8'h75, "up_break");
    key(8'h75, "unmapped");
    key(8'h1C, "norm_after");
    key(8'hF0, "a_f0b");
    key(8'h1C, "a_breakb");
    key(8'h12, "lshift");
    key(8'h1C, "a_again");
    key(8'hF0, "ls_f0");
    key(8'h12, "ls_break");

    bad_frame(8'h5A, 1, 0, "bad_par");
    bad_frame(8'h5A, 0, 1, "bad_stop");

    p0 = err_pulses; c0 = err_cycles;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (int'(TO) + 50) @(posedge mck);
    @(negedge mck);
    check("tmo_pulses", 64'(err_pulses - p0), 64'd1);
    check("tmo_cycles", 64'(err_cycles - c0), 64'd1);
    key(8'h76, "esc_after_tmo");

    key(8'hE1, "pause0");
    key(8'h14, "pause1");
    key(8'h77, "pause2");
    key(8'hE1, "pause3");
    key(8'hF0, "pause4");
    key(8'h14, "pause5");
    key(8'hF0, "pause6");
    key(8'h77, "pause7");
    key(8'h00, "overflow");

    key(8'h5A, "enter");
    key(8'hE0, "pend_e0");
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    @(posedge mck);
    #1 rin_n = 1'b0;
    @(posedge mck);
    #1;
    check("mid_rst_mat", bus.kbmat, 64'd0);
    check("mid_rst_act", {63'd0, bus.kbact}, 64'd0);
    check("mid_rst_err", {63'd0, bus.kb_err}, 64'd0);
    rin_n = 1'b1;
    bus.ps2_dat = 1'b1;
    model_clear();
    repeat (4) @(posedge mck);
    key(8'h75, "post_rst_75");

    p0 = err_pulses;
    for (int n = 0; n < 50; n++) begin
      b = pool[$urandom_range(0, 17)];
      key(b, "rnd");
    end
    check("rnd_no_err", 64'(err_pulses - p0), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ps2_kbmat.md
# ps2_kbmat

PS/2 keyboard front end that builds the 64-bit Z88 key matrix consumed by the Blink's `kbmat` input, where bit `row*8+col` is 1 while the key is held. It samples the asynchronous PS/2 clock and data lines in the `mck` domain and receives 11-bit frames. It decodes scan-code set 2 make/break sequences, including E0-extended keys, and keeps one level bit per matrix key. The Blink combines these bits with `ca[15:8]` when software reads port $B2.

## Interface
Parameters:
- `TIMEOUT`, default 16'd9830: mck cycles (~1 ms) without a PS/2 falling edge before a partial frame is abandoned.
- `FILT`, default 3: consecutive equal synchronized samples required to accept a new `ps2_clk` level.

Ports:
- `mck`  in  1  9.83 MHz master clock. Only clock.
- `rin_n`  in  1  reset. Synchronous and active-low.
- `ps2_clk`  in  1  PS/2 clock, asynchronous, open-drain.
- `ps2_dat`  in  1  PS/2 data, asynchronous.
- `kbmat`  out  64  key state. 1 = pressed. Index = row*8+col; row n is the row selected by ca[8+n].
- `kbact`  out  1  OR of all `kbmat` bits (any key held).
- `kb_err`  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- **Input path:**
  - 2-FF synchronizer on both lines.
  - The `ps2_clk` glitch filter changes its output only after FILT identical synchronized samples.
  - A falling edge of the filtered clock yields a one-cycle `fall` strobe.
  - Data is taken from the synchronized `ps2_dat` in the `fall` cycle.
- **Frame FSM:**
  - IDLE: a `fall` with dat=0 goes to DATA with bit counter 0.
  - DATA: shift in 8 bits, LSB first, then go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: valid frame (odd parity over the 9 bits, stop=1) gives a one-cycle `byte_vld` with `byte`; a bad frame pulses `kb_err`. Return to IDLE in both cases.
  - IDLE with dat=1 on `fall` stays in IDLE.
  - Timeout counter clears on every `fall`. In any non-IDLE state, reaching TIMEOUT gives IDLE and a `kb_err` pulse.
- **Decode FSM** (advances on `byte_vld` only). States: NORM, BRK, EXT, EXTBRK, SKIP.
  - NORM: E0 → EXT; F0 → BRK; E1 → SKIP with skip count 7; 00 or FF (overflow) → clear all of `kbmat`; AA, FA, FE ignored. Any other code is looked up; if mapped, set its bit.
  - BRK: lookup; if mapped, clear its bit. Then → NORM.
  - EXT: F0 → EXTBRK; otherwise extended lookup, set bit, → NORM.
  - EXTBRK: extended lookup, clear bit, → NORM.
  - SKIP: decrement the count; → NORM at 0.
  - Unmapped codes change no bit but still return the FSM to NORM.
- **Key map** (combinational), from `{ext, code[7:0]}` to `{hit, idx[5:0]}`. Entries required by the test plan:
  - 5A → 6 (ENTER)
  - 76 → 61 (ESC)
  - 12 → 54 (LSHIFT)
  - 59 → 63 (RSHIFT)
  - 1C → 45 ('A')
  - E0 75 → 11 (UP)
  - E0 72 → 10 (DOWN)
  - E0 6B → 12 (LEFT)
  - E0 74 → 13 (RIGHT)
  - The full table lives in the package.
- Multiple keys may be held at once; bits are independent.
- Repeated makes (typematic) re-set an already-set bit, which is harmless.

## Timing
- Reset values: `kbmat`=0, `kbact`=0, `kb_err`=0, both FSMs in IDLE/NORM, counters 0.
- Reset during a frame discards the partial byte and any pending E0/F0/E1 context.
- Latency: a pin edge reaches `fall` 2 (synchronizer) + FILT cycles later.
- From the `fall` of the stop bit:
  - `byte_vld` and `kb_err` are asserted in the next cycle (N+1).
  - `kbmat` updates at N+2; `kbact` at N+3.
- `kb_err` is asserted for exactly one cycle per bad frame.
- The bit counter wraps nowhere: it ranges 0–7 and is cleared on return to IDLE.
- The timeout counter saturates at TIMEOUT while in IDLE; no error is raised in IDLE.
- Simultaneous `byte_vld` and reset: reset wins.
- `kbmat` is glitch-free, a registered output, and stable between updates.

## Structure
- Package `ps2_pkg`:
  - Decode state enum.
  - Prefix constants: E0, E1, F0, AA, FA, FE, 00, FF.
  - Skip length 7.
  - Key-map table of constant `{ext, code, idx}` entries.
- One sub-module, `ps2_keymap`: purely combinational lookup `{ext, code}` → `{hit, idx}`.
- Top level contains the synchronizer, filter, frame FSM, decode FSM and matrix register.

## Test plan
- Frame 1C → `kbmat[45]`=1 at stop-fall+2 and `kbact`=1. Then F0 1C → `kbmat`=0 and `kbact`=0.
- E0 75 → bit 11 set. E0 F0 75 → bit 11 cleared. Plain 75 (unmapped) → `kbmat` unchanged and decode FSM back in NORM.
- 12 followed by 1C → bits 54 and 45 both set. F0 12 → only bit 45 remains.
- Frame 5A with wrong parity → one-cycle `kb_err` and bit 6 unchanged. Frame with stop=0 → `kb_err`.
- 4 data bits then silence for TIMEOUT cycles → `kb_err`. A following valid 76 frame → bit 61 set.
- E1 14 77 E1 F0 14 F0 77 → no bit changes. Then 00 with keys held → `kbmat`=0. Assert `rin_n`=0 mid-frame → all outputs 0 on the next edge.
